control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes occur on the rising edge.
REQ-002 SHALL have port: clear  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: ir  input  32  instruction register contents; opcode is ir[31:27], Ra is ir[26:23], Rb is ir[22:19], Rc is ir[18:15].
REQ-004 SHALL have port: mem_ready  input  1  memory read data valid on Mdatain during T1.
REQ-005 SHALL have port: stop  input  1  request to halt at the next instruction boundary.
REQ-006 SHALL have outputs, each 1 bit: PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin.
REQ-007 SHALL have outputs: reg_in  output  16  one-hot R0in..R15in; reg_out  output  16  one-hot R0out..R15out.
REQ-008 SHALL have ALU select outputs, each 1 bit, at most one high: ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
REQ-009 SHALL have outputs: run  output  1  high while not halted; illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-010 SHALL be a Moore FSM with states RST, T0, T1, T2, T3, T4, T5, T6, HALT; all outputs SHALL be registered and derived from the next state.
REQ-011 T0 SHALL assert PCout, MARin, IncPC and Zlowin; the next state is T1.
REQ-012 T1 SHALL assert Zlowout and PCin for the first T1 cycle only.
REQ-013 T1 SHALL assert MDMuxread and MDRin until mem_ready=1, then advance to T2; while mem_ready=0 it SHALL stay in T1 indefinitely.
REQ-014 T2 SHALL assert MDRout and IRin; ir SHALL be sampled for decode on entry to T3.
REQ-015 T3 SHALL assert reg_out[Rb] and Yin.
REQ-016 T4 SHALL assert Zlowin and the decoded ALU bit; for two-operand ops it SHALL also assert reg_out[Rc], and for NEG/NOT reg_out[Rb] only.
REQ-017 T5 SHALL assert Zlowout; for ALU ops it SHALL also assert reg_in[Ra], then return to T0.
REQ-018 Opcode map: add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11, mul 15, div 16, neg 17, not 18, nop 26, halt 27.
REQ-019 nop SHALL return from T2 to T0; halt SHALL go from T2 to HALT.
REQ-020 Any other opcode SHALL pulse illegal in the cycle after T2 and return to T0 with no register write.
REQ-021 stop=1 sampled in T5, or in T2 of a nop, SHALL enter HALT instead of T0.
REQ-022 HALT SHALL deassert run and all controls; it is left only by reset.
REQ-023 reg_in and reg_out SHALL never have more than one bit high and SHALL never both be nonzero toward the same register in one state.
REQ-024 Every control not named for a state SHALL be 0 in that state.

Reset
REQ-025 clear=0 SHALL immediately force state RST, all outputs 0 and run=0, including mid-instruction or mid-T1 wait.
REQ-026 The first rising edge with clear=1 SHALL move RST to T0 and set run=1.

Configuration
REQ-027 Macro CONTROL_SEQUENCER_MULDIV_EN defined: mul and div SHALL be decoded; T4 asserts MUL/DIV with reg_out[Rb], Zlowin and Zhighin; T5 asserts Zlowout and LOin; T6 asserts Zhighout and HIin, then T0.
REQ-028 Macro undefined: opcodes 15 and 16 SHALL be illegal per REQ-020, and state T6 SHALL be unreachable.

Structure
REQ-029 Package cu_pkg SHALL hold the opcode constants, the state encoding and the field bit positions.
REQ-030 A combinational sub-module cu_op_decode SHALL map opcode to the one-hot ALU select, a two-operand flag and a legal flag.
REQ-031 The 4-to-16 register decode SHALL be inline.

Verification
REQ-032 Reset: clear low mid-T4 -> all outputs 0 asynchronously, and T0 controls appear one edge after release.
REQ-033 ir=0x18918000, mem_ready=1 -> T3 reg_out=0x0004 with Yin; T4 reg_out=0x0008 with ADD and Zlowin; T5 reg_in=0x0002 with Zlowout.
REQ-034 mem_ready held 0 for 3 cycles in T1 -> PCin high only on the first T1 cycle, MDRin high for 4 cycles, then T2.
REQ-035 ir opcode 31 -> illegal pulses once, no reg_in bit set, and the next cycle is T0.
REQ-036 ir opcode 15 with Ra=4, Rb=5, Rc=6 under CONTROL_SEQUENCER_MULDIV_EN -> T5 LOin, T6 HIin, and reg_in stays 0.
REQ-037 Opcode 15 without the macro -> illegal pulse; opcode 27, or stop=1 in T5 -> HALT with run=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state encoding,
// instruction field positions, ALU select indices and the control word layout.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  localparam int IR_W    = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam int ALU_W    = 13;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_MUL  = 2;
  localparam int ALU_DIV  = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef struct packed {
    logic              pc_out;
    logic              pc_in;
    logic              inc_pc;
    logic              mar_in;
    logic              mdr_in;
    logic              mdr_out;
    logic              md_mux_read;
    logic              ir_in;
    logic              y_in;
    logic              zlow_in;
    logic              zhigh_in;
    logic              zlow_out;
    logic              zhigh_out;
    logic              hi_in;
    logic              lo_in;
    logic [15:0]       reg_in;
    logic [15:0]       reg_out;
    logic [ALU_W-1:0]  alu;
    logic              run;
    logic              illegal;
  } ctrl_t;

endpackage

// File: rtl/cu_op_decode.sv
// Opcode to one-hot ALU select, two-operand flag and legal flag.
// MUL/DIV decode only when CONTROL_SEQUENCER_MULDIV_EN is defined.
module cu_op_decode
  import cu_pkg::*;
(
  input  logic [4:0]       opcode,
  output logic [ALU_W-1:0] alu_sel,
  output logic             two_op,
  output logic             legal
);

  always_comb begin
    alu_sel = '0;
    two_op  = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OP_ADD:  begin alu_sel[ALU_ADD]  = 1'b1; two_op = 1'b1; end
      OP_SUB:  begin alu_sel[ALU_SUB]  = 1'b1; two_op = 1'b1; end
      OP_AND:  begin alu_sel[ALU_AND]  = 1'b1; two_op = 1'b1; end
      OP_OR:   begin alu_sel[ALU_OR]   = 1'b1; two_op = 1'b1; end
      OP_SHR:  begin alu_sel[ALU_SHR]  = 1'b1; two_op = 1'b1; end
      OP_SHRA: begin alu_sel[ALU_SHRA] = 1'b1; two_op = 1'b1; end
      OP_SHL:  begin alu_sel[ALU_SHL]  = 1'b1; two_op = 1'b1; end
      OP_ROR:  begin alu_sel[ALU_ROR]  = 1'b1; two_op = 1'b1; end
      OP_ROL:  begin alu_sel[ALU_ROL]  = 1'b1; two_op = 1'b1; end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
      OP_MUL:  alu_sel[ALU_MUL] = 1'b1;
      OP_DIV:  alu_sel[ALU_DIV] = 1'b1;
`endif
      OP_NEG:  alu_sel[ALU_NEG] = 1'b1;
      OP_NOT:  alu_sel[ALU_NOT] = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), execute (T3-T6), HALT; all outputs registered
// from the next state. Optional MUL/DIV support: CONTROL_SEQUENCER_MULDIV_EN.
module control_sequencer
  import cu_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            MDMuxread,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zhighin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic [15:0]     reg_in,
  output logic [15:0]     reg_out,
  output logic            ADD,
  output logic            SUB,
  output logic            MUL,
  output logic            DIV,
  output logic            AND,
  output logic            OR,
  output logic            SHR,
  output logic            SHRA,
  output logic            SHL,
  output logic            ROR,
  output logic            ROL,
  output logic            NEG,
  output logic            NOT,
  output logic            run,
  output logic            illegal
);

  state_t                 state, state_next;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [OPC_MSB:RC_LSB]  ir_q, dec_ir;
  logic [4:0]             opcode;
  logic [3:0]             ra, rb, rc;
  logic [ALU_W-1:0]       alu_sel;
  logic                   two_op, legal, is_muldiv;
  logic                   unused_ir_low;

  assign unused_ir_low = ^ir[RC_LSB-1:0];

  // In T2 decode straight from ir; afterwards from the copy captured on T2 exit.
  assign dec_ir = (state == ST_T2) ? ir[OPC_MSB:RC_LSB] : ir_q;
  assign opcode = dec_ir[OPC_MSB:OPC_LSB];
  assign ra     = dec_ir[RA_MSB:RA_LSB];
  assign rb     = dec_ir[RB_MSB:RB_LSB];
  assign rc     = dec_ir[RC_MSB:RC_LSB];

  cu_op_decode u_op_decode (
    .opcode  (opcode),
    .alu_sel (alu_sel),
    .two_op  (two_op),
    .legal   (legal)
  );

`ifdef CONTROL_SEQUENCER_MULDIV_EN
  assign is_muldiv = alu_sel[ALU_MUL] | alu_sel[ALU_DIV];
`else
  assign is_muldiv = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (state == ST_T2) ir_q <= ir[OPC_MSB:RC_LSB];
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= ST_RST;
      ctrl_q <= '0;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    state_next = state;
    ctrl_d     = '0;
    case (state)
      ST_RST:  state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   if (mem_ready) state_next = ST_T2;
      ST_T2: begin
        if (opcode == OP_NOP)       state_next = stop ? ST_HALT : ST_T0;
        else if (opcode == OP_HALT) state_next = ST_HALT;
        else if (legal)             state_next = ST_T3;
        else begin
          state_next     = ST_T0;
          ctrl_d.illegal = 1'b1;
        end
      end
      ST_T3:   state_next = ST_T4;
      ST_T4:   state_next = ST_T5;
      ST_T5: begin
        if (is_muldiv) state_next = ST_T6;
        else           state_next = stop ? ST_HALT : ST_T0;
      end
      ST_T6:   state_next = stop ? ST_HALT : ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RST;
    endcase

    // Control word for the state about to be entered.
    ctrl_d.run = !(state_next inside {ST_RST, ST_HALT});
    case (state_next)
      ST_T0: begin
        ctrl_d.pc_out  = 1'b1;
        ctrl_d.mar_in  = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
        ctrl_d.zlow_in = 1'b1;
      end
      ST_T1: begin
        ctrl_d.md_mux_read = 1'b1;
        ctrl_d.mdr_in      = 1'b1;
        ctrl_d.zlow_out    = (state != ST_T1);
        ctrl_d.pc_in       = (state != ST_T1);
      end
      ST_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      ST_T3: begin
        ctrl_d.reg_out = 16'b1 << rb;
        ctrl_d.y_in    = 1'b1;
      end
      ST_T4: begin
        ctrl_d.zlow_in  = 1'b1;
        ctrl_d.zhigh_in = is_muldiv;
        ctrl_d.alu      = alu_sel;
        ctrl_d.reg_out  = two_op ? (16'b1 << rc) : (16'b1 << rb);
      end
      ST_T5: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.lo_in    = is_muldiv;
        ctrl_d.reg_in   = is_muldiv ? 16'h0000 : (16'b1 << ra);
      end
      ST_T6: begin
        ctrl_d.zhigh_out = 1'b1;
        ctrl_d.hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCout     = ctrl_q.pc_out;
  assign PCin      = ctrl_q.pc_in;
  assign IncPC     = ctrl_q.inc_pc;
  assign MARin     = ctrl_q.mar_in;
  assign MDRin     = ctrl_q.mdr_in;
  assign MDRout    = ctrl_q.mdr_out;
  assign MDMuxread = ctrl_q.md_mux_read;
  assign IRin      = ctrl_q.ir_in;
  assign Yin       = ctrl_q.y_in;
  assign Zlowin    = ctrl_q.zlow_in;
  assign Zhighin   = ctrl_q.zhigh_in;
  assign Zlowout   = ctrl_q.zlow_out;
  assign Zhighout  = ctrl_q.zhigh_out;
  assign HIin      = ctrl_q.hi_in;
  assign LOin      = ctrl_q.lo_in;
  assign reg_in    = ctrl_q.reg_in;
  assign reg_out   = ctrl_q.reg_out;
  assign ADD       = ctrl_q.alu[ALU_ADD];
  assign SUB       = ctrl_q.alu[ALU_SUB];
  assign MUL       = ctrl_q.alu[ALU_MUL];
  assign DIV       = ctrl_q.alu[ALU_DIV];
  assign AND       = ctrl_q.alu[ALU_AND];
  assign OR        = ctrl_q.alu[ALU_OR];
  assign SHR       = ctrl_q.alu[ALU_SHR];
  assign SHRA      = ctrl_q.alu[ALU_SHRA];
  assign SHL       = ctrl_q.alu[ALU_SHL];
  assign ROR       = ctrl_q.alu[ALU_ROR];
  assign ROL       = ctrl_q.alu[ALU_ROL];
  assign NEG       = ctrl_q.alu[ALU_NEG];
  assign NOT       = ctrl_q.alu[ALU_NOT];
  assign run       = ctrl_q.run;
  assign illegal   = ctrl_q.illegal;

endmodule
